// File: rtl/dial_tracker_param.sv
// Rotary dial tracker: walks the dial one position (or one full revolution) per
// cycle and accumulates zero landings, zero-ending instructions and completions.
module dial_tracker_param #(
  parameter int DIAL_SIZE   = 100,
  parameter int START_POS   = 50,
  parameter int COUNT_WIDTH = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int FAST_WRAP   = 0,
  localparam int PW         = $clog2(DIAL_SIZE)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instruction_valid,
  input  logic                   direction,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   clear,
  output logic                   instruction_ready,
  output logic                   busy,
  output logic                   instr_done,
  output logic [PW-1:0]          dial_position,
  output logic [ACC_WIDTH-1:0]   hits,
  output logic [ACC_WIDTH-1:0]   passes,
  output logic [ACC_WIDTH-1:0]   instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_FINISH} state_e;

  localparam int RW = COUNT_WIDTH + 32;
  localparam logic [PW-1:0]          POS_MAX   = PW'(DIAL_SIZE - 1);
  localparam logic [PW-1:0]          POS_START = PW'(START_POS);
  localparam logic [ACC_WIDTH-1:0]   ACC_MAX   = '1;
  localparam logic [RW-1:0]          DIAL_W    = RW'(DIAL_SIZE);
  localparam logic [COUNT_WIDTH-1:0] DIAL_C    = COUNT_WIDTH'(DIAL_SIZE);

  state_e                 state_q, state_d;
  logic [PW-1:0]          pos_q, pos_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic                   dir_q, dir_d;
  logic [ACC_WIDTH-1:0]   hits_q, hits_d, passes_q, passes_d, icnt_q, icnt_d;
  logic                   pass_inc, hit_inc, done_inc, fast_ok;

  function automatic logic [ACC_WIDTH-1:0] sat_inc(input logic [ACC_WIDTH-1:0] v,
                                                   input logic en);
    return (en && v != ACC_MAX) ? v + ACC_WIDTH'(1) : v;
  endfunction

  // DIAL_C is only used once rem_q >= DIAL_SIZE, so its truncation never matters
  assign fast_ok = (FAST_WRAP != 0) && (RW'(rem_q) >= DIAL_W);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    pass_inc = 1'b0;
    hit_inc  = 1'b0;
    done_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instruction_valid && count != '0) begin
          rem_d   = count;
          dir_d   = direction;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (fast_ok) begin
          rem_d    = rem_q - DIAL_C;
          pass_inc = 1'b1;
        end else begin
          if (dir_q) pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
          else       pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
          pass_inc = (pos_d == '0);
          rem_d    = rem_q - COUNT_WIDTH'(1);
        end
        if (rem_d == '0) state_d = S_FINISH;
      end
      S_FINISH: begin
        hit_inc  = (pos_q == '0);
        done_inc = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      hits_d   = '0;
      passes_d = '0;
      icnt_d   = '0;
    end else begin
      hits_d   = sat_inc(hits_q, hit_inc);
      passes_d = sat_inc(passes_q, pass_inc);
      icnt_d   = sat_inc(icnt_q, done_inc);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pos_q    <= POS_START;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      hits_q   <= '0;
      passes_q <= '0;
      icnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      hits_q   <= hits_d;
      passes_q <= passes_d;
      icnt_q   <= icnt_d;
    end
  end

  assign instruction_ready = (state_q == S_IDLE);
  assign busy              = ~instruction_ready;
  assign instr_done        = (state_q == S_FINISH);
  assign dial_position     = pos_q;
  assign hits              = hits_q;
  assign passes            = passes_q;
  assign instr_count       = icnt_q;

endmodule

// File: tb/tb_dial_tracker_param.sv
// Scoreboarded bench for dial_tracker_param: unit 0 uses defaults, unit 1 uses
// FAST_WRAP=1 with 4-bit saturating accumulators.
module tb_dial_tracker_param;
  localparam int D  = 100;
  localparam int CW = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       valid, dir, clr, rdy, bsy, done;
  logic [1:0][CW-1:0] cnt;
  logic [1:0][6:0]  pos;
  logic [31:0]      hits_a, passes_a, icnt_a;
  logic [3:0]       hits_b, passes_b, icnt_b;
  logic [1:0]       mon_en;

  always #5 clock = ~clock;

  dial_tracker_param u_a (
    .clock(clock), .reset(reset), .instruction_valid(valid[0]), .direction(dir[0]),
    .count(cnt[0]), .clear(clr[0]), .instruction_ready(rdy[0]), .busy(bsy[0]),
    .instr_done(done[0]), .dial_position(pos[0]), .hits(hits_a), .passes(passes_a),
    .instr_count(icnt_a));

  dial_tracker_param #(.FAST_WRAP(1), .ACC_WIDTH(4)) u_b (
    .clock(clock), .reset(reset), .instruction_valid(valid[1]), .direction(dir[1]),
    .count(cnt[1]), .clear(clr[1]), .instruction_ready(rdy[1]), .busy(bsy[1]),
    .instr_done(done[1]), .dial_position(pos[1]), .hits(hits_b), .passes(passes_b),
    .instr_count(icnt_b));

  typedef struct {
    longint pos, pass, hits, icnt, steps, acc_cyc;
  } exp_t;

  exp_t   q0[$], q1[$];
  int     tests = 0, fails = 0;
  longint cyc = 0;
  longint m_pos[2], m_hits[2], m_pass[2], m_icnt[2];
  longint acc_max[2] = '{64'hFFFF_FFFF, 15};
  bit     fast[2] = '{1'b0, 1'b1};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic longint g_hits(int u);
    return u == 0 ? longint'(hits_a) : longint'(hits_b);
  endfunction
  function automatic longint g_pass(int u);
    return u == 0 ? longint'(passes_a) : longint'(passes_b);
  endfunction
  function automatic longint g_icnt(int u);
    return u == 0 ? longint'(icnt_a) : longint'(icnt_b);
  endfunction

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void sb_push(int u, exp_t e);
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic int sb_size(int u);
    return u == 0 ? q0.size() : q1.size();
  endfunction
  function automatic exp_t sb_pop(int u);
    return u == 0 ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic longint sat(int u, longint v);
    return v > acc_max[u] ? acc_max[u] : v;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pos[u] = 50; m_hits[u] = 0; m_pass[u] = 0; m_icnt[u] = 0;
    end
  endfunction

  // Closed-form outcome of an n-step move: final position and number of zero landings.
  function automatic exp_t model_run(int u, bit d, longint n);
    exp_t   e;
    longint p = m_pos[u], np, npass;
    if (d) begin
      np    = (p + n) % D;
      npass = (p + n) / D;
    end else begin
      np = (((p - n) % D) + D) % D;
      if (p == 0)      npass = n / D;
      else if (n >= p) npass = (n - p) / D + 1;
      else             npass = 0;
    end
    m_pos[u]  = np;
    m_pass[u] = sat(u, m_pass[u] + npass);
    m_hits[u] = sat(u, m_hits[u] + ((np == 0) ? 1 : 0));
    m_icnt[u] = sat(u, m_icnt[u] + 1);
    e.pos = np; e.pass = m_pass[u]; e.hits = m_hits[u]; e.icnt = m_icnt[u];
    e.steps = fast[u] ? (n / D + n % D) : n;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Waits for ready (spraying junk while busy), offers one instruction, returns
  // at the negedge after the accepting edge.
  task automatic issue(int u, bit d, int n, bit push);
    int   w = 0;
    exp_t e;
    @(negedge clock);
    while (!rdy[u] && w < 5000) begin
      valid[u] = 1'($urandom);
      dir[u]   = 1'($urandom);
      cnt[u]   = CW'($urandom);
      w++;
      @(negedge clock);
    end
    chk($sformatf("u%0d_ready_timeout", u), longint'(rdy[u]), 1);
    valid[u] = 1'b1;
    dir[u]   = d;
    cnt[u]   = CW'(n);
    if (push && n != 0) begin
      e = model_run(u, d, n);
      e.acc_cyc = cyc + 1;
      sb_push(u, e);
    end
    @(negedge clock);
    valid[u] = 1'b0;
    cnt[u]   = CW'($urandom);
  endtask

  task automatic wait_idle(int u);
    int w = 0;
    do begin
      @(negedge clock);
      w++;
    end while ((sb_size(u) != 0 || !rdy[u]) && w < 5000);
    chk($sformatf("u%0d_idle_timeout", u), sb_size(u), 0);
    repeat (2) @(negedge clock);
  endtask

  // FINISH is presented 'steps' edges after the accepting edge; hits and
  // instr_count settle on the following edge.
  task automatic monitor(int u);
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en[u] && done[u]) begin
        if (sb_size(u) == 0) begin
          chk($sformatf("u%0d_unexpected_done", u), sb_size(u), 1);
        end else begin
          e = sb_pop(u);
          chk($sformatf("u%0d_pos", u), longint'(pos[u]), e.pos);
          chk($sformatf("u%0d_passes", u), g_pass(u), e.pass);
          chk($sformatf("u%0d_latency", u), cyc - e.acc_cyc, e.steps);
          @(negedge clock);
          chk($sformatf("u%0d_hits", u), g_hits(u), e.hits);
          chk($sformatf("u%0d_icnt", u), g_icnt(u), e.icnt);
          chk($sformatf("u%0d_ready_after", u), longint'(rdy[u]), 1);
          chk($sformatf("u%0d_done_pulse", u), longint'(done[u]), 0);
        end
      end
    end
  endtask

  task automatic chk_state(int u, string tag, longint p, longint h, longint ps, longint ic,
                           longint r);
    chk($sformatf("%s_pos", tag), longint'(pos[u]), p);
    chk($sformatf("%s_hits", tag), g_hits(u), h);
    chk($sformatf("%s_passes", tag), g_pass(u), ps);
    chk($sformatf("%s_icnt", tag), g_icnt(u), ic);
    chk($sformatf("%s_ready", tag), longint'(rdy[u]), r);
    chk($sformatf("%s_busy", tag), longint'(bsy[u]), 1 - r);
    chk($sformatf("%s_done", tag), longint'(done[u]), 0);
  endtask

  task automatic rand_drv(int u);
    int n;
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 400));
      issue(u, 1'($urandom), n, 1'b1);
    end
    wait_idle(u);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    valid = '0; dir = '0; clr = '0; cnt = '0; mon_en = 2'b11;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk_state(0, "rst_a", 50, 0, 0, 0, 1);
    chk_state(1, "rst_b", 50, 0, 0, 0, 1);
    reset = 1'b1;
    fork monitor(0); monitor(1); join_none

    // Back-to-back L68, L30, R48 on the default unit
    issue(0, 1'b0, 68, 1'b1);
    issue(0, 1'b0, 30, 1'b1);
    issue(0, 1'b1, 48, 1'b1);
    wait_idle(0);
    chk_state(0, "seq_a", 0, 1, 2, 3, 1);

    // Zero-count instruction on the default unit changes nothing
    issue(0, 1'b1, 0, 1'b1);
    chk_state(0, "zero_a", 0, 1, 2, 3, 1);

    // Full revolutions collapse into single cycles on the fast unit
    issue(1, 1'b1, 1000, 1'b1);
    wait_idle(1);
    chk_state(1, "fast_b", 50, 0, 10, 1, 1);
    issue(1, 1'b0, 0, 1'b1);
    chk_state(1, "zero_b", 50, 0, 10, 1, 1);
    issue(1, 1'b1, 50, 1'b1);
    wait_idle(1);
    chk_state(1, "r50_b", 0, 1, 11, 2, 1);
    repeat (20) issue(1, 1'b1, 100, 1'b1);
    wait_idle(1);
    chk_state(1, "sat_b", 0, 15, 15, 15, 1);

    fork rand_drv(0); rand_drv(1); join

    // clear during FINISH beats the hit/instr_count increment
    mon_en[0] = 1'b0;
    issue(0, 1'b1, (m_pos[0] == 0) ? D : int'(D - m_pos[0]), 1'b0);
    m_pos[0] = 0;
    w = 0;
    while (!done[0] && w < 1000) begin
      @(negedge clock);
      w++;
    end
    chk("clr_done_seen", longint'(done[0]), 1);
    clr[0] = 1'b1;
    @(negedge clock);
    clr[0] = 1'b0;
    chk_state(0, "clr_a", 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of an L200
    issue(0, 1'b0, 200, 1'b0);
    repeat (5) @(negedge clock);
    chk("mid_busy", longint'(bsy[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk_state(0, "arst_a", 50, 0, 0, 0, 1);
    chk_state(1, "arst_b", 50, 0, 0, 0, 1);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    mon_en[0] = 1'b1;
    issue(0, 1'b1, 50, 1'b1);
    wait_idle(0);
    chk_state(0, "post_rst_a", 0, 1, 1, 1, 1);

    chk("q0_leftover", q0.size(), 0);
    chk("q1_leftover", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
